// File: rtl/jump_field_encoder.sv
// Jump-immediate encoder: latches a jump request, checks alignment and region,
// and emits the 12-bit word-address immediate together with fault flags and a
// saturating count of faulty requests.
module jump_field_encoder #(
  parameter int unsigned ERR_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [15:0]          TargetAddr,
  input  logic [15:0]          CurrentPC,
  input  logic                 ClearErrors,
  output logic                 Busy,
  output logic                 Done,
  output logic [11:0]          JumpField,
  output logic [1:0]           RegionBits,
  output logic                 Misaligned,
  output logic                 OutOfRegion,
  output logic                 FieldValid,
  output logic [ERR_WIDTH-1:0] ErrorCount
);

  typedef enum logic [1:0] {StIdle, StLatch, StCheck, StDone} state_e;

  state_e state_q, state_d;

  logic [15:0]          addr_q;
  logic [15:0]          pc_q;
  logic [11:0]          field_q;
  logic [1:0]           region_q;
  logic                 misaligned_q;
  logic                 out_of_region_q;
  logic                 valid_q;
  logic [ERR_WIDTH-1:0] err_q;

  logic misaligned_c;
  logic out_of_region_c;
  logic err_sat;

  // Fault checks work only on the latched copies so later input changes are invisible.
  assign misaligned_c    = (addr_q[1:0] != 2'b00);
  assign out_of_region_c = (addr_q[15:14] != pc_q[15:14]);
  assign err_sat         = (err_q == {ERR_WIDTH{1'b1}});

  // Next-state logic; Start is only looked at in IDLE, so requests during Busy are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start) state_d = StLatch;
      StLatch: state_d = StCheck;
      StCheck: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, operand latches, result registers and fault counter.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      pc_q            <= '0;
      field_q         <= '0;
      region_q        <= '0;
      misaligned_q    <= 1'b0;
      out_of_region_q <= 1'b0;
      valid_q         <= 1'b0;
      err_q           <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StLatch) begin
        addr_q <= TargetAddr;
        pc_q   <= CurrentPC;
      end
      if (state_q == StCheck) begin
        field_q         <= addr_q[13:2];
        region_q        <= addr_q[15:14];
        misaligned_q    <= misaligned_c;
        out_of_region_q <= out_of_region_c;
        valid_q         <= ~(misaligned_c | out_of_region_c);
      end
      // Clear wins over the increment that happens on the CHECK->DONE edge.
      if (ClearErrors) begin
        err_q <= '0;
      end else if ((state_q == StCheck) && (misaligned_c | out_of_region_c) && !err_sat) begin
        err_q <= err_q + ERR_WIDTH'(1);
      end
    end
  end

  assign Busy        = (state_q != StIdle);
  assign Done        = (state_q == StDone);
  assign JumpField   = field_q;
  assign RegionBits  = region_q;
  assign Misaligned  = misaligned_q;
  assign OutOfRegion = out_of_region_q;
  assign FieldValid  = valid_q;
  assign ErrorCount  = err_q;

endmodule
